// File: rtl/axi_write_arbiter_if.sv
// AXI4 write-channel bundle (AW/W/B) between the store arbiter and the SoC fabric.
interface axi_write_arbiter_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid;
  logic        wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bresp, bid
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/axi_write_arbiter.sv
// Two-requester AXI4 single-beat write arbiter: grants r0/r1, aligns data and
// strobes onto the 64-bit bus and routes the B response back to the granted side.
module axi_write_arbiter #(
  parameter logic [3:0] AXI_ID = 4'b0001,
  parameter bit         RR_EN  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       r0_valid,
  output logic                       r0_ready,
  input  logic [31:0]                r0_addr,
  input  logic [2:0]                 r0_size,
  input  logic [63:0]                r0_data,
  output logic                       r0_bvalid,
  input  logic                       r0_bready,
  output logic                       r0_berr,
  input  logic                       r1_valid,
  output logic                       r1_ready,
  input  logic [31:0]                r1_addr,
  input  logic [2:0]                 r1_size,
  input  logic [63:0]                r1_data,
  output logic                       r1_bvalid,
  input  logic                       r1_bready,
  output logic                       r1_berr,
  axi_write_arbiter_if.master        axi,
  output logic                       arb_error
);

  typedef enum logic [1:0] {IDLE, SEND, RESP, OVER} state_t;

  state_t      state, state_next;
  logic        grant, grant_q, last_grant;
  logic        accept, done_take;
  logic [31:0] sel_addr;
  logic [2:0]  sel_size;
  logic [63:0] sel_data;
  logic [7:0]  base_strb;
  logic [2:0]  lsb_mask;
  logic        misaligned;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic        err_pend, aw_done, w_done, err_q;

  assign axi.awid    = AXI_ID;
  assign axi.awlen   = '0;
  assign axi.awburst = 2'b01;
  assign axi.wlast   = axi.wvalid;
  assign axi.awaddr  = addr_q;
  assign axi.awsize  = size_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;

  // Pick the requester to serve; with both pending, round-robin or r0 priority.
  always_comb begin
    grant = 1'b0;
    if (r0_valid && r1_valid) grant = RR_EN ? ~last_grant : 1'b0;
    else if (r1_valid)        grant = 1'b1;
    sel_addr = grant ? r1_addr : r0_addr;
    sel_size = grant ? r1_size : r0_size;
    sel_data = grant ? r1_data : r0_data;
  end

  // Byte-lane strobe pattern and natural-alignment check for the selected request.
  always_comb begin
    base_strb = '0;
    lsb_mask  = '0;
    case (sel_size)
      3'd0: begin base_strb = 8'h01; lsb_mask = 3'b000; end
      3'd1: begin base_strb = 8'h03; lsb_mask = 3'b001; end
      3'd2: begin base_strb = 8'h0F; lsb_mask = 3'b011; end
      3'd3: begin base_strb = 8'hFF; lsb_mask = 3'b111; end
      default: begin base_strb = '0; lsb_mask = '0; end
    endcase
    misaligned = (sel_size > 3'd3) || ((sel_addr[2:0] & lsb_mask) != 3'b000);
  end

  // Next-state and handshake outputs for the IDLE/SEND/RESP/OVER sequence.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    done_take   = 1'b0;
    r0_ready    = 1'b0;
    r1_ready    = 1'b0;
    r0_bvalid   = 1'b0;
    r1_bvalid   = 1'b0;
    r0_berr     = 1'b0;
    r1_berr     = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    case (state)
      IDLE: begin
        if (r0_valid || r1_valid) begin
          accept     = 1'b1;
          r0_ready   = ~grant;
          r1_ready   = grant;
          state_next = SEND;
        end
      end
      SEND: begin
        axi.awvalid = ~aw_done;
        axi.wvalid  = ~w_done;
        // a done flag masks its ready, so AW and W may finish in either order
        if ((aw_done || axi.awready) && (w_done || axi.wready)) state_next = RESP;
      end
      RESP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_next = OVER;
      end
      OVER: begin
        r0_bvalid = ~grant_q;
        r1_bvalid = grant_q;
        r0_berr   = ~grant_q & err_q;
        r1_berr   = grant_q & err_q;
        if (grant_q ? r1_bready : r0_bready) begin
          done_take  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Request capture, channel-done tracking, response error and grant history.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      err_pend   <= 1'b0;
      grant_q    <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      err_q      <= 1'b0;
      last_grant <= 1'b1;
      arb_error  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= sel_addr;
        size_q   <= sel_size;
        wdata_q  <= sel_data << {sel_addr[2:0], 3'b000};
        wstrb_q  <= misaligned ? '0 : (base_strb << sel_addr[2:0]);
        err_pend <= misaligned;
        grant_q  <= grant;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end
      if (state == SEND) begin
        if (state_next == RESP) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          aw_done <= aw_done | axi.awready;
          w_done  <= w_done | axi.wready;
        end
      end
      if (state == RESP && axi.bvalid)
        err_q <= err_pend | (axi.bresp != 2'b00) | (axi.bid != AXI_ID);
      if (done_take) begin
        last_grant <= grant_q;
        arb_error  <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: alignment vectors, arbitration order,
// channel ordering, error responses and mid-transaction reset.
module tb_axi_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_ready, r0_bvalid, r0_bready, r0_berr;
  logic        r1_valid, r1_ready, r1_bvalid, r1_bready, r1_berr;
  logic [31:0] r0_addr, r1_addr;
  logic [2:0]  r0_size, r1_size;
  logic [63:0] r0_data, r1_data;
  logic        arb_error;
  logic        fp_r0_ready, fp_r1_ready, fp_r0_bvalid, fp_r1_bvalid;
  logic        fp_r0_berr, fp_r1_berr, fp_arb_error;

  int n_checks = 0;
  int n_errors = 0;

  axi_write_arbiter_if bus ();
  axi_write_arbiter_if bus_fp ();

  always #5 clk = ~clk;

  axi_write_arbiter #(.AXI_ID(4'b0001), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_size(r0_size),
    .r0_data(r0_data), .r0_bvalid(r0_bvalid), .r0_bready(r0_bready), .r0_berr(r0_berr),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_size(r1_size),
    .r1_data(r1_data), .r1_bvalid(r1_bvalid), .r1_bready(r1_bready), .r1_berr(r1_berr),
    .axi(bus), .arb_error(arb_error)
  );

  axi_write_arbiter #(.AXI_ID(4'b0001), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(fp_r0_ready), .r0_addr(r0_addr), .r0_size(r0_size),
    .r0_data(r0_data), .r0_bvalid(fp_r0_bvalid), .r0_bready(r0_bready), .r0_berr(fp_r0_berr),
    .r1_valid(r1_valid), .r1_ready(fp_r1_ready), .r1_addr(r1_addr), .r1_size(r1_size),
    .r1_data(r1_data), .r1_bvalid(fp_r1_bvalid), .r1_bready(r1_bready), .r1_berr(fp_r1_berr),
    .axi(bus_fp), .arb_error(fp_arb_error)
  );

  // Configurable slave on the main bus: ready after a programmable wait, B one cycle after AW+W.
  int          aw_dly = 0, w_dly = 0;
  int          aw_cnt = 0, w_cnt = 0;
  int          aw_hs = 0, w_hs = 0, b_hs = 0;
  logic        aw_seen = 1'b0, w_seen = 1'b0, s_bvalid = 1'b0;
  logic [1:0]  s_bresp = 2'b00;
  logic [3:0]  s_bid = 4'b0001;

  assign bus.awready = bus.awvalid && (aw_cnt >= aw_dly);
  assign bus.wready  = bus.wvalid && (w_cnt >= w_dly);
  assign bus.bvalid  = s_bvalid;
  assign bus.bresp   = s_bresp;
  assign bus.bid     = s_bid;

  always @(posedge clk) begin : slave_main
    logic aw_now, w_now;
    aw_now = aw_seen | (bus.awvalid & bus.awready);
    w_now  = w_seen | (bus.wvalid & bus.wready);
    if (rst) begin
      aw_seen <= 1'b0; w_seen <= 1'b0; s_bvalid <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
    end else begin
      if (bus.awvalid && bus.awready) begin aw_hs <= aw_hs + 1; aw_cnt <= 0; end
      else if (bus.awvalid) aw_cnt <= aw_cnt + 1;
      if (bus.wvalid && bus.wready) begin w_hs <= w_hs + 1; w_cnt <= 0; end
      else if (bus.wvalid) w_cnt <= w_cnt + 1;
      if (s_bvalid && bus.bready) begin s_bvalid <= 1'b0; b_hs <= b_hs + 1; end
      if (aw_now && w_now && !s_bvalid) begin
        s_bvalid <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
      end else begin
        aw_seen <= aw_now; w_seen <= w_now;
      end
    end
  end

  // Always-ready OKAY slave for the fixed-priority instance.
  logic s2_bvalid = 1'b0;
  assign bus_fp.awready = 1'b1;
  assign bus_fp.wready  = 1'b1;
  assign bus_fp.bvalid  = s2_bvalid;
  assign bus_fp.bresp   = 2'b00;
  assign bus_fp.bid     = 4'b0001;

  always @(posedge clk) begin
    if (rst) s2_bvalid <= 1'b0;
    else if (s2_bvalid && bus_fp.bready) s2_bvalid <= 1'b0;
    else if (bus_fp.awvalid && bus_fp.wvalid) s2_bvalid <= 1'b1;
  end

  // Cycle counter and grant/handshake monitor sampled mid-cycle.
  int cyc = 0;
  bit q_grant[$];
  int q_cyc[$];
  int both_cnt = 0, bready_cyc = 0, fp_r0_cnt = 0, fp_r1_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (r0_ready || r1_ready) begin
        q_grant.push_back(r1_ready);
        q_cyc.push_back(cyc);
      end
      if (r0_ready && r1_ready) both_cnt <= both_cnt + 1;
      if (bus.bready) bready_cyc <= bready_cyc + 1;
      if (fp_r0_ready) fp_r0_cnt <= fp_r0_cnt + 1;
      if (fp_r1_ready) fp_r1_cnt <= fp_r1_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request on one side and hold it until accepted; returns in the cycle after accept.
  task automatic issue(input bit side, input logic [31:0] a, input logic [2:0] s, input logic [63:0] d);
    @(posedge clk); #1;
    if (side) begin r1_addr = a; r1_size = s; r1_data = d; r1_valid = 1'b1; end
    else      begin r0_addr = a; r0_size = s; r0_data = d; r0_valid = 1'b1; end
    @(negedge clk);
    for (int i = 0; i < 40 && !(side ? r1_ready : r0_ready); i++) @(negedge clk);
    check("accept", side ? r1_ready : r0_ready, 1'b1);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
  endtask

  // Count negedges until the requester sees its completion; lat = -1 on timeout.
  task automatic wait_done(input bit side, input int k0, output int lat, output logic be);
    lat = k0;
    be  = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (side ? r1_bvalid : r0_bvalid) begin
        be = side ? r1_berr : r0_berr;
        return;
      end
      lat++;
    end
    lat = -1;
  endtask

  // One transaction against a zero-wait slave with full output checks.
  task automatic run_vec(input bit side, input logic [31:0] a, input logic [2:0] s,
                         input logic [63:0] d, input logic [63:0] exp_wdata,
                         input logic [7:0] exp_wstrb, input logic exp_err);
    int   lat;
    logic be;
    issue(side, a, s, d);
    @(negedge clk);
    check("awvalid", bus.awvalid, 1'b1);
    check("wlast", bus.wlast, 1'b1);
    check("awaddr", bus.awaddr, a);
    check("awsize", bus.awsize, s);
    check("wdata", bus.wdata, exp_wdata);
    check("wstrb", bus.wstrb, exp_wstrb);
    wait_done(side, 2, lat, be);
    check("b_latency", lat, 3);
    check("berr", be, exp_err);
    check("other_bvalid", side ? r0_bvalid : r1_bvalid, 1'b0);
    @(negedge clk);
    check("arb_error", arb_error, exp_err);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   lat, a0, w0, b0, br0, n0, f0, f1;
    logic be;
    rst = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_addr = '0; r1_addr = '0; r0_size = '0; r1_size = '0; r0_data = '0; r1_data = '0;
    r0_bready = 1'b1; r1_bready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_awvalid", bus.awvalid, 1'b0);
    check("rst_wvalid", bus.wvalid, 1'b0);
    check("rst_bready", bus.bready, 1'b0);
    check("rst_awaddr", bus.awaddr, 32'h0);
    check("rst_wdata", bus.wdata, 64'h0);
    check("rst_wstrb", bus.wstrb, 8'h0);
    check("rst_arb_error", arb_error, 1'b0);
    check("rst_bvalid", {r0_bvalid, r1_bvalid}, 2'b00);
    check("const_awid", bus.awid, 4'b0001);
    check("const_awlen", bus.awlen, 8'h00);
    check("const_awburst", bus.awburst, 2'b01);

    // Both requesters pending every cycle
    n0 = q_grant.size(); f0 = fp_r0_cnt; f1 = fp_r1_cnt;
    @(posedge clk); #1;
    r0_addr = 32'h1000; r0_size = 3'd3; r0_data = 64'h1111;
    r1_addr = 32'h2008; r1_size = 3'd3; r1_data = 64'h2222;
    r0_valid = 1'b1; r1_valid = 1'b1;
    repeat (16) @(posedge clk);
    #1 r0_valid = 1'b0; r1_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rr_count", q_grant.size() - n0, 4);
    if (q_grant.size() >= n0 + 4) begin
      for (int i = 0; i < 4; i++) check("rr_grant", q_grant[n0 + i], i % 2);
      check("rr_spacing", q_cyc[n0 + 3] - q_cyc[n0], 12);
    end
    check("fp_r0_grants", fp_r0_cnt - f0, 4);
    check("fp_r1_grants", fp_r1_cnt - f1, 0);

    // Alignment and misalignment vectors
    run_vec(1'b0, 32'h8000_0004, 3'd2, 64'hDEADBEEF, 64'hDEADBEEF_00000000, 8'hF0, 1'b0);
    run_vec(1'b1, 32'h8000_0002, 3'd2, 64'h11223344, 64'h0000_1122_3344_0000, 8'h00, 1'b1);
    run_vec(1'b0, 32'h0000_0006, 3'd1, 64'hABCD,     64'hABCD_0000_0000_0000, 8'hC0, 1'b0);
    run_vec(1'b1, 32'h0000_0007, 3'd0, 64'h5A,       64'h5A00_0000_0000_0000, 8'h80, 1'b0);
    run_vec(1'b0, 32'h0000_0010, 3'd3, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 8'hFF, 1'b0);
    run_vec(1'b1, 32'h0000_0004, 3'd3, 64'h1,        64'h0000_0001_0000_0000, 8'h00, 1'b1);

    // Slave error response, wrong bid, then a clean write clears arb_error
    s_bresp = 2'b10;
    run_vec(1'b1, 32'h100, 3'd2, 64'hCAFE, 64'hCAFE, 8'h0F, 1'b1);
    s_bresp = 2'b00; s_bid = 4'b0000;
    run_vec(1'b1, 32'h104, 3'd2, 64'hBEEF, 64'hBEEF_0000_0000, 8'hF0, 1'b1);
    s_bid = 4'b0001;
    run_vec(1'b0, 32'h108, 3'd3, 64'h55, 64'h55, 8'hFF, 1'b0);

    // W ready well before AW, then the reverse
    for (int dir = 0; dir < 2; dir++) begin
      aw_dly = (dir == 0) ? 3 : 0;
      w_dly  = (dir == 0) ? 0 : 3;
      a0 = aw_hs; w0 = w_hs; b0 = b_hs; br0 = bready_cyc;
      issue(dir[0], 32'h3000, 3'd3, 64'hA5A5);
      @(negedge clk);
      @(negedge clk);
      check("order_awvalid", bus.awvalid, (dir == 0) ? 1'b1 : 1'b0);
      check("order_wvalid", bus.wvalid, (dir == 0) ? 1'b0 : 1'b1);
      wait_done(dir[0], 3, lat, be);
      check("order_latency", lat, 6);
      @(negedge clk);
      check("order_aw_count", aw_hs - a0, 1);
      check("order_w_count", w_hs - w0, 1);
      check("order_b_count", b_hs - b0, 1);
      check("order_resp_cycles", bready_cyc - br0, 1);
    end
    aw_dly = 0; w_dly = 0;

    // Reset while in SEND, with arb_error set beforehand
    run_vec(1'b0, 32'h0, 3'd4, 64'h77, 64'h77, 8'h00, 1'b1);
    issue(1'b0, 32'h200, 3'd3, 64'hFFFF_0000_FFFF);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("send_rst_awvalid", bus.awvalid, 1'b0);
    check("send_rst_wvalid", bus.wvalid, 1'b0);
    check("send_rst_awaddr", bus.awaddr, 32'h0);
    check("send_rst_wdata", bus.wdata, 64'h0);
    check("send_rst_awsize", bus.awsize, 3'd0);
    check("send_rst_arb_error", arb_error, 1'b0);

    // Reset while holding a completion in OVER
    r0_bready = 1'b0;
    issue(1'b0, 32'h300, 3'd2, 64'h1234);
    wait_done(1'b0, 1, lat, be);
    check("over_latency", lat, 3);
    @(negedge clk);
    check("over_hold", r0_bvalid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; r0_bready = 1'b1;
    @(negedge clk);
    check("over_rst_bvalid", r0_bvalid, 1'b0);
    check("over_rst_bready", bus.bready, 1'b0);
    check("over_rst_awaddr", bus.awaddr, 32'h0);
    check("over_rst_wstrb", bus.wstrb, 8'h0);

    run_vec(1'b1, 32'h0000_0003, 3'd0, 64'hEE, 64'hEE00_0000, 8'h08, 1'b0);
    check("never_both_ready", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
